// File: rtl/drc_pkg.sv
// Shared descriptor layout, AXI encodings and FSM state type for the DMA read controller
// write path.
package drc_pkg;

    localparam int unsigned DESC_W        = 40;
    localparam int unsigned DESC_CNT_LSB  = 0;
    localparam int unsigned DESC_CNT_W    = 8;
    localparam int unsigned DESC_ADDR_LSB = 8;
    localparam int unsigned DESC_ADDR_W   = 32;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROTO_DEFAULT = 3'b000;
    localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } wr_state_e;

endpackage

// File: rtl/drc_sync_fifo.sv
// Small synchronous FIFO with an occupancy count; the caller guarantees it never over- or
// under-flows.
module drc_sync_fifo #(
    parameter  int unsigned p_width = 1,
    parameter  int unsigned p_depth = 4,
    localparam int unsigned CNT_W   = $clog2(p_depth + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [p_width-1:0] i_wdata,
    input  logic               i_pop,
    output logic [p_width-1:0] o_rdata,
    output logic [CNT_W-1:0]   o_count
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(p_depth - 1);

    logic [p_width-1:0] r_mem [p_depth];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/drc_axi_burst_writer.sv
// AXI4 write master: round-robin over descriptor/data FIFO pairs, one INCR burst per
// descriptor, with a bounded number of bursts awaiting B and per-path sticky error flags.
module drc_axi_burst_writer
    import drc_pkg::*;
#(
    parameter int unsigned p_paths           = 2,
    parameter int unsigned p_data_width      = 128,
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [p_paths-1:0]              i_paths_burst_empty,
    input  logic [p_paths*DESC_W-1:0]       i_paths_burst_in,
    output logic [p_paths-1:0]              o_paths_burst_rd,
    input  logic [p_paths-1:0]              i_paths_data_empty,
    input  logic [p_paths*p_data_width-1:0] i_paths_data_in,
    output logic [p_paths-1:0]              o_paths_data_rd,
    output logic [31:0]                     awaddr,
    output logic [7:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic [3:0]                      awcache,
    output logic [2:0]                      awproto,
    output logic                            awvalid,
    input  logic                            awready,
    output logic [p_data_width-1:0]         wdata,
    output logic [p_data_width/8-1:0]       wstrb,
    output logic                            wlast,
    output logic                            wvalid,
    input  logic                            wready,
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready,
    output logic [p_paths-1:0]              o_err,
    input  logic [p_paths-1:0]              i_err_clr,
    output logic                            o_busy
);

    localparam int unsigned TAG_W = (p_paths > 1) ? $clog2(p_paths) : 1;
    localparam int unsigned CNT_W = $clog2(p_max_outstanding + 1);

    wr_state_e          r_state;
    logic [TAG_W-1:0]   r_last;
    logic [TAG_W-1:0]   r_gnt;
    logic [31:0]        r_awaddr;
    logic [7:0]         r_awlen;
    logic [7:0]         r_beats;
    logic               r_awvalid;
    logic [p_paths-1:0] r_burst_rd;
    logic [p_paths-1:0] r_err;

    logic               w_grant_vld;
    logic [TAG_W-1:0]   w_grant;
    logic [TAG_W-1:0]   w_idx;
    logic [DESC_W-1:0]  w_desc;
    logic [7:0]         w_cnt_m1;
    logic               w_can_issue;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_b_err;
    logic [TAG_W-1:0]   w_tag;
    logic [CNT_W-1:0]   w_count;
    logic [p_paths-1:0] w_err_set;
    logic [p_paths-1:0] w_data_rd;

    // First non-empty path strictly after the last grant, wrapping around.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int unsigned i = 1; i <= p_paths; i++) begin
            w_idx = TAG_W'((32'(r_last) + i) % p_paths);
            if (!w_grant_vld && !i_paths_burst_empty[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_desc      = i_paths_burst_in[w_grant*DESC_W +: DESC_W];
    assign w_cnt_m1    = w_desc[DESC_CNT_LSB +: DESC_CNT_W] - 8'd1;
    assign w_can_issue = (w_count < CNT_W'(p_max_outstanding));

    assign w_aw_hs = r_awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_b_hs  = bvalid && bready;
    assign w_b_err = bresp inside {AXI_RESP_SLVERR, AXI_RESP_DECERR};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_last     <= TAG_W'(p_paths - 1);
            r_gnt      <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_beats    <= '0;
            r_awvalid  <= 1'b0;
            r_burst_rd <= '0;
        end else begin
            r_burst_rd <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_grant_vld && w_can_issue) begin
                        r_gnt               <= w_grant;
                        r_last              <= w_grant;
                        r_awaddr            <= w_desc[DESC_ADDR_LSB +: DESC_ADDR_W];
                        r_awlen             <= w_cnt_m1;
                        r_beats             <= w_cnt_m1;
                        r_awvalid           <= 1'b1;
                        r_burst_rd[w_grant] <= 1'b1;
                        r_state             <= StAddr;
                    end
                end
                StAddr: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (w_w_hs) begin
                        if (r_beats == 8'd0) begin
                            r_state <= StIdle;
                        end else begin
                            r_beats <= r_beats - 8'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Tag FIFO occupancy doubles as the outstanding-burst count.
    drc_sync_fifo #(
        .p_width (TAG_W),
        .p_depth (p_max_outstanding)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_aw_hs),
        .i_wdata (r_gnt),
        .i_pop   (w_b_hs),
        .o_rdata (w_tag),
        .o_count (w_count)
    );

    always_comb begin
        w_err_set = '0;
        if (w_b_hs && w_b_err) begin
            w_err_set[w_tag] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~i_err_clr) | w_err_set;
        end
    end

    always_comb begin
        w_data_rd        = '0;
        w_data_rd[r_gnt] = w_w_hs;
    end

    assign o_paths_burst_rd = r_burst_rd;
    assign o_paths_data_rd  = w_data_rd;

    assign awaddr  = r_awaddr;
    assign awlen   = r_awlen;
    assign awsize  = 3'($clog2(p_data_width / 8));
    assign awburst = AXI_BURST_INCR;
    assign awcache = AXI_CACHE_DEFAULT;
    assign awproto = AXI_PROTO_DEFAULT;
    assign awvalid = r_awvalid;

    assign wdata  = i_paths_data_in[r_gnt*p_data_width +: p_data_width];
    assign wstrb  = '1;
    assign wvalid = (r_state == StData) && !i_paths_data_empty[r_gnt];
    assign wlast  = (r_state == StData) && (r_beats == 8'd0);

    assign bready = (w_count != '0);
    assign o_err  = r_err;
    assign o_busy = (r_state != StIdle) || (w_count != '0);

endmodule

// File: tb/tb_drc_axi_burst_writer.sv
// Directed bench for drc_axi_burst_writer: FWFT FIFO models on the path side, a scripted
// AXI slave on the bus side, a table of single-burst vectors and hand-written corner cases.
module tb_drc_axi_burst_writer;

    localparam int unsigned NP = 2;
    localparam int unsigned DW = 128;
    localparam int unsigned MO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     burst_empty;
    logic [NP*40-1:0]  burst_in;
    logic [NP-1:0]     burst_rd;
    logic [NP-1:0]     data_empty;
    logic [NP*DW-1:0]  data_in;
    logic [NP-1:0]     data_rd;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [3:0]        awcache;
    logic [2:0]        awproto;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [NP-1:0]     err;
    logic [NP-1:0]     err_clr;
    logic              busy;

    drc_axi_burst_writer #(
        .p_paths           (NP),
        .p_data_width      (DW),
        .p_max_outstanding (MO)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_paths_burst_empty (burst_empty),
        .i_paths_burst_in    (burst_in),
        .o_paths_burst_rd    (burst_rd),
        .i_paths_data_empty  (data_empty),
        .i_paths_data_in     (data_in),
        .o_paths_data_rd     (data_rd),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awsize              (awsize),
        .awburst             (awburst),
        .awcache             (awcache),
        .awproto             (awproto),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bresp               (bresp),
        .bvalid              (bvalid),
        .bready              (bready),
        .o_err               (err),
        .i_err_clr           (err_clr),
        .o_busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned path;
        logic [31:0] addr;
        logic [7:0]  cnt;
        logic [1:0]  resp;
        logic [7:0]  exp_awlen;
        int unsigned exp_beats;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [5];

    logic [39:0] desc_q [NP][$];
    logic [DW-1:0] data_q [NP][$];
    int          grant_log [$];
    logic [31:0] aw_addr_log [$];
    logic [31:0] serial = 32'd1;

    int n_checks = 0;
    int n_pass = 0;
    int aw_seen, beats_seen, last_seen, pending_b, b_credit, beat_idx, cur_path;
    logic [7:0] cur_len;
    logic       auto_b;
    logic [1:0] bresp_val, clr_manual, clr_mask;
    logic       clr_on_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_fifos();
        for (int p = 0; p < NP; p++) begin
            burst_empty[p]       = (desc_q[p].size() == 0);
            burst_in[p*40 +: 40] = (desc_q[p].size() != 0) ? desc_q[p][0] : 40'h0;
            data_empty[p]        = (data_q[p].size() == 0);
            data_in[p*DW +: DW]  = (data_q[p].size() != 0) ? data_q[p][0] : '0;
        end
        bvalid  = (auto_b || b_credit > 0) && (pending_b > 0);
        bresp   = bresp_val;
        err_clr = clr_on_b ? (bvalid ? clr_mask : 2'b00) : clr_manual;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_fifos();
        #1;
    endtask

    task automatic clear_logs();
        aw_seen = 0;
        beats_seen = 0;
        last_seen = 0;
        grant_log.delete();
        aw_addr_log.delete();
    endtask

    task automatic push_burst(input int unsigned p, input logic [31:0] addr,
                              input logic [7:0] cnt);
        int unsigned n;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        for (int unsigned k = 0; k < n; k++) begin
            data_q[p].push_back({8'(p), 88'h0, serial});
            serial++;
        end
        desc_q[p].push_back({addr, cnt});
        drive_fifos();
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((busy || desc_q[0].size() != 0 || desc_q[1].size() != 0 || pending_b != 0)
               && n < max_cyc) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 128'(n >= max_cyc), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            desc_q[p].delete();
            data_q[p].delete();
        end
        pending_b = 0;
        b_credit = 0;
        auto_b = 1'b1;
        bresp_val = 2'b00;
        clr_manual = 2'b00;
        clr_mask = 2'b00;
        clr_on_b = 1'b0;
        awready = 1'b1;
        wready = 1'b1;
        drive_fifos();
        clear_logs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Bus-side observer: pops the FIFO models and checks every beat against them.
    always @(posedge clk) begin
        if (rst_n) begin
            if (burst_rd != '0) begin
                check("burst_rd_onehot", 128'($onehot(burst_rd)), 128'(1));
                for (int p = 0; p < NP; p++) begin
                    if (burst_rd[p]) begin
                        grant_log.push_back(p);
                        cur_path = p;
                        if (desc_q[p].size() != 0) void'(desc_q[p].pop_front());
                    end
                end
            end
            if (awvalid && awready) begin
                aw_seen++;
                aw_addr_log.push_back(awaddr);
                cur_len = awlen;
                beat_idx = 0;
            end
            if (wvalid && wready) begin
                if (data_q[cur_path].size() != 0) check("wdata", wdata, data_q[cur_path][0]);
                check("data_rd_path", 128'(data_rd), 128'(NP'(1) << cur_path));
                check("wlast_pos", 128'(wlast), 128'(beat_idx == int'(cur_len)));
                beats_seen++;
                beat_idx++;
                if (wlast) begin
                    last_seen++;
                    pending_b++;
                end
            end else if (data_rd != '0) begin
                check("data_rd_idle", 128'(data_rd), 128'(0));
            end
            for (int p = 0; p < NP; p++) begin
                if (data_rd[p] && data_q[p].size() != 0) void'(data_q[p].pop_front());
            end
            if (bvalid && bready) begin
                pending_b--;
                if (b_credit > 0) b_credit--;
            end
        end
    end

    initial begin
        int n;
        logic pv, pr;
        logic [DW-1:0] pd;

        vecs[0] = '{0, 32'h1000_0000, 8'd4, 2'b00, 8'd3,   4,   2'b00};
        vecs[1] = '{1, 32'h2000_0040, 8'd1, 2'b00, 8'd0,   1,   2'b00};
        vecs[2] = '{0, 32'h3000_0100, 8'd0, 2'b00, 8'd255, 256, 2'b00};
        vecs[3] = '{1, 32'h4000_0000, 8'd3, 2'b10, 8'd2,   3,   2'b10};
        vecs[4] = '{0, 32'h5000_0000, 8'd2, 2'b11, 8'd1,   2,   2'b11};

        rst_n = 1'b0;
        pending_b = 0;
        b_credit = 0;
        auto_b = 1'b1;
        bresp_val = 2'b00;
        clr_manual = 2'b00;
        clr_mask = 2'b00;
        clr_on_b = 1'b0;
        awready = 1'b1;
        wready = 1'b1;
        cur_path = 0;
        cur_len = 8'd0;
        beat_idx = 0;
        clear_logs();
        drive_fifos();
        #12;
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_bready", 128'(bready), 128'(0));
        check("rst_burst_rd", 128'(burst_rd), 128'(0));
        check("rst_data_rd", 128'(data_rd), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("awsize", 128'(awsize), 128'(4));
        check("awburst", 128'(awburst), 128'(1));
        check("awcache", 128'(awcache), 128'(3));
        check("awproto", 128'(awproto), 128'(0));
        check("wstrb", 128'(wstrb), 128'hFFFF);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            bresp_val = vecs[v].resp;
            push_burst(vecs[v].path, vecs[v].addr, vecs[v].cnt);
            tick();
            check("vec_awvalid", 128'(awvalid), 128'(1));
            check("vec_awaddr", 128'(awaddr), 128'(vecs[v].addr));
            check("vec_awlen", 128'(awlen), 128'(vecs[v].exp_awlen));
            wait_idle("vec_done", 400);
            check("vec_aw_count", 128'(aw_seen), 128'(1));
            check("vec_beats", 128'(beats_seen), 128'(vecs[v].exp_beats));
            check("vec_last_count", 128'(last_seen), 128'(1));
            check("vec_err", 128'(err), 128'(vecs[v].exp_err));
            check("vec_bready_low", 128'(bready), 128'(0));
        end

        clr_manual = 2'b01;
        drive_fifos();
        tick();
        clr_manual = 2'b00;
        drive_fifos();
        check("clr_bit0", 128'(err), 128'(2'b10));
        clr_manual = 2'b10;
        drive_fifos();
        tick();
        clr_manual = 2'b00;
        drive_fifos();
        check("clr_bit1", 128'(err), 128'(2'b00));

        bresp_val = 2'b10;
        clr_on_b = 1'b1;
        clr_mask = 2'b10;
        push_burst(1, 32'h8000_0000, 8'd1);
        wait_idle("setclr_done", 50);
        clr_on_b = 1'b0;
        drive_fifos();
        check("set_beats_clr", 128'(err), 128'(2'b10));
        clr_manual = 2'b10;
        drive_fifos();
        tick();
        clr_manual = 2'b00;
        drive_fifos();
        check("clr_after_set", 128'(err), 128'(2'b00));

        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_burst(0, 32'h7000_0000 + 32'(k) * 32'h100, 8'd2);
            push_burst(1, 32'h7000_1000 + 32'(k) * 32'h100, 8'd2);
        end
        wait_idle("alt_done", 200);
        check("alt_grants", 128'(grant_log.size()), 128'(6));
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check("alt_grant", 128'(grant_log[i]), 128'(i % 2));
            check("alt_awaddr", 128'(aw_addr_log[i]),
                  128'(32'h7000_0000 + 32'(i % 2) * 32'h1000 + 32'(i / 2) * 32'h100));
        end
        check("alt_beats", 128'(beats_seen), 128'(12));

        do_reset();
        awready = 1'b0;
        wready = 1'b0;
        push_burst(0, 32'h6000_0000, 8'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_awvalid", 128'(awvalid), 128'(1));
            check("stall_awaddr", 128'(awaddr), 128'(32'h6000_0000));
            tick();
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("aw_done_awvalid", 128'(awvalid), 128'(0));
        check("aw_done_wvalid", 128'(wvalid), 128'(1));
        for (int i = 0; i < 20 && last_seen == 0; i++) begin
            wready = ~wready;
            pv = wvalid;
            pr = wready;
            pd = wdata;
            tick();
            if (pv && !pr) begin
                check("stall_wvalid", 128'(wvalid), 128'(1));
                check("stall_wdata", wdata, pd);
            end
        end
        wready = 1'b1;
        awready = 1'b1;
        wait_idle("stall_done", 50);
        check("stall_beats", 128'(beats_seen), 128'(3));
        check("stall_last", 128'(last_seen), 128'(1));

        do_reset();
        auto_b = 1'b0;
        for (int k = 0; k < 5; k++) push_burst(0, 32'h9000_0000 + 32'(k) * 32'h100, 8'd1);
        repeat (30) tick();
        check("ost_aw_count", 128'(aw_seen), 128'(4));
        check("ost_awvalid", 128'(awvalid), 128'(0));
        check("ost_bready", 128'(bready), 128'(1));
        check("ost_busy", 128'(busy), 128'(1));
        check("ost_desc_left", 128'(desc_q[0].size()), 128'(1));
        b_credit = 1;
        drive_fifos();
        n = 0;
        while (aw_seen < 5 && n < 10) begin
            tick();
            n++;
        end
        check("ost_fifth", 128'(aw_seen), 128'(5));
        auto_b = 1'b1;
        drive_fifos();
        wait_idle("ost_drain", 100);
        check("ost_last", 128'(last_seen), 128'(5));

        do_reset();
        auto_b = 1'b0;
        push_burst(0, 32'hA000_0000, 8'd1);
        n = 0;
        while (last_seen < 1 && n < 20) begin
            tick();
            n++;
        end
        check("mid_first", 128'(last_seen), 128'(1));
        wready = 1'b0;
        push_burst(1, 32'hB000_0000, 8'd8);
        repeat (3) tick();
        check("mid_pre_wvalid", 128'(wvalid), 128'(1));
        check("mid_pre_bready", 128'(bready), 128'(1));
        check("mid_pre_busy", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_awvalid", 128'(awvalid), 128'(0));
        check("mid_wvalid", 128'(wvalid), 128'(0));
        check("mid_bready", 128'(bready), 128'(0));
        check("mid_busy", 128'(busy), 128'(0));
        check("mid_burst_rd", 128'(burst_rd), 128'(0));
        check("mid_data_rd", 128'(data_rd), 128'(0));
        check("mid_err", 128'(err), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
